// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: streams operand nibbles LSB-first through one
// 4-bit prefix adder, carrying between cycles through a register.

module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic       g0c;
  logic       g10, g21, g32;
  logic       p21, p32;
  logic       c1, c2, c3, c4;

  assign p = a ^ b;
  assign g = a & b;

  // cin is folded into bit-0 generate so the prefix tree needs no extra level
  assign g0c = g[0] | (p[0] & cin);

  assign g10 = g[1] | (p[1] & g0c);
  assign g21 = g[2] | (p[2] & g[1]);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p21 = p[2] & p[1];
  assign p32 = p[3] & p[2];

  assign c1 = g0c;
  assign c2 = g10;
  assign c3 = g21 | (p21 & g0c);
  assign c4 = g32 | (p32 & g10);

  assign sum  = p ^ {c3, c2, c1, cin};
  assign cout = c4;

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             in_ready_r;
  logic             out_valid_r;

  adder u_adder (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Written as shift-then-overlay so WIDTH == 4 needs no special case
  always_comb begin
    result_next              = result >> 4;
    result_next[WIDTH-1 -: 4] = nib_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      result      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= a;
            b_sh       <= b;
            carry      <= cin;
            cnt        <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
          end
        end
        RUN: begin
          result <= result_next;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          carry  <= nib_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = result;
  assign cout      = carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH 16, 4 and 32.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv16, ir16, ov16, or16, cin16, co16;
  logic [15:0] a16, b16, s16;
  logic        iv4, ir4, ov4, or4, cin4, co4;
  logic [3:0]  a4, b4, s4;
  logic        iv32, ir32, ov32, or32, cin32, co32;
  logic [31:0] a32, b32, s32;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic [32:0] q32[$];

  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ir16); end
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov16); end
    n_checks++; if (s16 !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", s16); end
    n_checks++; if (co16 !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", co16); end
    n_checks++; if (ir4 !== 1'b1 || ir32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_w4_w32: got %b %b expected 1 1", ir4, ir32); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [16:0] exp;
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_before_accept: got %b expected 1", ir16); end
    q16.push_back(17'h05555);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) iv16 = 1'b0;
      n_checks++;
      if (ov16 !== (i == 4)) begin n_fail++; $display("FAIL basic_latency_cycle%0d: out_valid got %b expected %b", i, ov16, (i == 4)); end
    end
    exp = q16.pop_front();
    n_checks++; if ({co16, s16} !== exp) begin n_fail++; $display("FAIL basic_sum: got %h expected %h", {co16, s16}, exp); end
    @(negedge clk);
    n_checks++; if (ov16 !== 1'b0 || ir16 !== 1'b1) begin n_fail++; $display("FAIL basic_one_cycle_valid: out_valid %b in_ready %b expected 0 1", ov16, ir16); end
  endtask

  task automatic test_carry();
    logic [15:0] va[2];
    logic [15:0] vb[2];
    logic [16:0] ve[2];
    logic [16:0] exp;
    int          t;
    va = '{16'hFFFF, 16'hFFFF};
    vb = '{16'h0000, 16'hFFFF};
    ve = '{17'h10000, 17'h1FFFF};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a16 = va[k]; b16 = vb[k]; cin16 = 1'b1; iv16 = 1'b1; or16 = 1'b1;
      q16.push_back(ve[k]);
      @(negedge clk);
      iv16 = 1'b0;
      t = 0;
      while (!ov16 && t < 20) begin @(negedge clk); t++; end
      exp = q16.pop_front();
      n_checks++;
      if (!ov16) begin n_fail++; $display("FAIL carry_timeout_%0d: out_valid got 0 expected 1", k); end
      else if ({co16, s16} !== exp) begin n_fail++; $display("FAIL carry_sum_%0d: got %h expected %h", k, {co16, s16}, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    int          t;
    @(negedge clk);
    a16 = 16'h0F0F; b16 = 16'h1010; cin16 = 1'b1; iv16 = 1'b1; or16 = 1'b0;
    q16.push_back(17'h01F20);
    @(negedge clk);
    iv16 = 1'b0;
    t = 0;
    while (!ov16 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (!ov16) begin n_fail++; $display("FAIL bp_timeout: out_valid got 0 expected 1"); end
    a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; iv16 = 1'b1;
    exp = q16[0];
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({co16, s16} !== exp || ir16 !== 1'b0 || ov16 !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: result %h in_ready %b out_valid %b expected %h 0 1", k, {co16, s16}, ir16, ov16, exp);
      end
      @(negedge clk);
    end
    or16 = 1'b1;
    exp = q16.pop_front();
    n_checks++; if ({co16, s16} !== exp) begin n_fail++; $display("FAIL bp_release_sum: got %h expected %h", {co16, s16}, exp); end
    @(negedge clk);
    n_checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0) begin n_fail++; $display("FAIL bp_back_idle: in_ready %b out_valid %b expected 1 0", ir16, ov16); end
    q16.push_back(17'h10000);
    @(negedge clk);
    n_checks++; if (ir16 !== 1'b0) begin n_fail++; $display("FAIL bp_pending_accept: in_ready got %b expected 0", ir16); end
    iv16 = 1'b0;
    t = 0;
    while (!ov16 && t < 20) begin @(negedge clk); t++; end
    exp = q16.pop_front();
    n_checks++; if ({co16, s16} !== exp || !ov16) begin n_fail++; $display("FAIL bp_pending_sum: got %h valid %b expected %h", {co16, s16}, ov16, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [16:0] exp;
    int          t;
    @(negedge clk);
    a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b0; iv16 = 1'b1; or16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ov16 !== 1'b0 || s16 !== 16'h0000 || co16 !== 1'b0 || ir16 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: out_valid %b sum %h cout %b in_ready %b expected 0 0000 0 1", ov16, s16, co16, ir16);
    end
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; iv16 = 1'b1;
    q16.push_back(17'h00002);
    @(negedge clk);
    iv16 = 1'b0;
    t = 0;
    while (!ov16 && t < 20) begin @(negedge clk); t++; end
    exp = q16.pop_front();
    n_checks++; if ({co16, s16} !== exp || !ov16) begin n_fail++; $display("FAIL midrun_next_op: got %h valid %b expected %h", {co16, s16}, ov16, exp); end
    @(negedge clk);
  endtask

  task automatic test_random16();
    int unsigned done = 0, guard = 0, t_acc = 0;
    logic        prev_ov = 1'b0;
    logic [16:0] exp;
    q16.delete();
    @(negedge clk);
    while (done < 1000 && guard < 40000) begin
      if (ov16 && !prev_ov) begin
        n_checks++; if (cyc - t_acc != 4) begin n_fail++; $display("FAIL rand16_latency: got %0d expected 4", cyc - t_acc); end
      end
      prev_ov = ov16;
      iv16 = ($urandom_range(0, 3) != 0); a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1)); or16 = ($urandom_range(0, 3) != 0);
      if (ov16 && or16) begin
        n_checks++;
        if (q16.size() == 0) begin n_fail++; $display("FAIL rand16_unexpected: got %h expected none", {co16, s16}); end
        else begin
          exp = q16.pop_front();
          if ({co16, s16} !== exp) begin n_fail++; $display("FAIL rand16_sum: got %h expected %h", {co16, s16}, exp); end
        end
        done++;
      end
      if (iv16 && ir16) begin
        q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
        t_acc = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    n_checks++; if (done < 1000) begin n_fail++; $display("FAIL rand16_timeout: completed %0d expected 1000", done); end
    iv16 = 1'b0; or16 = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_throughput();
    int unsigned n_acc = 0, guard = 0, prev_acc = 0;
    logic [16:0] exp;
    q16.delete();
    @(negedge clk);
    or16 = 1'b1;
    while ((n_acc < 6 || q16.size() != 0) && guard < 200) begin
      iv16 = (n_acc < 6); a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
      if (ov16 && or16) begin
        exp = q16.pop_front();
        n_checks++; if ({co16, s16} !== exp) begin n_fail++; $display("FAIL thru_sum: got %h expected %h", {co16, s16}, exp); end
      end
      if (iv16 && ir16) begin
        q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
        if (n_acc > 0) begin
          n_checks++; if (cyc - prev_acc != 6) begin n_fail++; $display("FAIL thru_interval: got %0d expected 6", cyc - prev_acc); end
        end
        prev_acc = cyc;
        n_acc++;
      end
      @(negedge clk);
      guard++;
    end
    n_checks++; if (n_acc < 6 || q16.size() != 0) begin n_fail++; $display("FAIL thru_timeout: accepts %0d pending %0d expected 6 0", n_acc, q16.size()); end
    iv16 = 1'b0;
  endtask

  task automatic test_random_w4();
    int unsigned done = 0, guard = 0, t_acc = 0;
    logic        prev_ov = 1'b0;
    logic [4:0]  exp;
    @(negedge clk);
    while (done < 300 && guard < 20000) begin
      if (ov4 && !prev_ov) begin
        n_checks++; if (cyc - t_acc != 1) begin n_fail++; $display("FAIL rand4_latency: got %0d expected 1", cyc - t_acc); end
      end
      prev_ov = ov4;
      iv4 = ($urandom_range(0, 3) != 0); a4 = 4'($urandom); b4 = 4'($urandom);
      cin4 = 1'($urandom_range(0, 1)); or4 = ($urandom_range(0, 3) != 0);
      if (ov4 && or4) begin
        n_checks++;
        if (q4.size() == 0) begin n_fail++; $display("FAIL rand4_unexpected: got %h expected none", {co4, s4}); end
        else begin
          exp = q4.pop_front();
          if ({co4, s4} !== exp) begin n_fail++; $display("FAIL rand4_sum: got %h expected %h", {co4, s4}, exp); end
        end
        done++;
      end
      if (iv4 && ir4) begin
        q4.push_back({1'b0, a4} + {1'b0, b4} + 5'(cin4));
        t_acc = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    n_checks++; if (done < 300) begin n_fail++; $display("FAIL rand4_timeout: completed %0d expected 300", done); end
    iv4 = 1'b0;
  endtask

  task automatic test_random_w32();
    int unsigned done = 0, guard = 0, t_acc = 0;
    logic        prev_ov = 1'b0;
    logic [32:0] exp;
    @(negedge clk);
    while (done < 300 && guard < 30000) begin
      if (ov32 && !prev_ov) begin
        n_checks++; if (cyc - t_acc != 8) begin n_fail++; $display("FAIL rand32_latency: got %0d expected 8", cyc - t_acc); end
      end
      prev_ov = ov32;
      iv32 = ($urandom_range(0, 3) != 0); a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); or32 = ($urandom_range(0, 3) != 0);
      if (ov32 && or32) begin
        n_checks++;
        if (q32.size() == 0) begin n_fail++; $display("FAIL rand32_unexpected: got %h expected none", {co32, s32}); end
        else begin
          exp = q32.pop_front();
          if ({co32, s32} !== exp) begin n_fail++; $display("FAIL rand32_sum: got %h expected %h", {co32, s32}, exp); end
        end
        done++;
      end
      if (iv32 && ir32) begin
        q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(cin32));
        t_acc = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    n_checks++; if (done < 300) begin n_fail++; $display("FAIL rand32_timeout: completed %0d expected 300", done); end
    iv32 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    iv4  = 1'b0; or4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
    test_random16();
    test_throughput();
    test_random_w4();
    test_random_w32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide-operand adder that reuses the team's 4-bit prefix adder (`adder`) as its datapath. It slices two WIDTH-bit operands into 4-bit nibbles and drives them through one `adder` instance, LSB nibble first. The carry is registered between cycles and the sum nibbles are collected into a result word. It sits upstream of the 4-bit adder, supplying its `a`, `b` and `cin`, and downstream of it, consuming its `sum` and `cout`. Wide additions therefore cost area of one 4-bit adder plus registers.

## Interface

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and cin valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

## Operation

- Exactly one `adder` instance. Its `a` and `b` inputs are the low nibbles of the A/B shift registers, and its `cin` is the carry register. No other arithmetic is in the datapath.
- States: IDLE, RUN, DONE. The counter `cnt` is max(1, clog2(NIBBLES)) bits wide.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch a and b into the shift registers, set carry reg to cin, set cnt to 0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: result register shifts right 4 bits with the adder `sum` entering bits [WIDTH-1:WIDTH-4].
  - A and B shift registers shift right 4 bits.
  - Carry reg takes adder `cout`. cnt increments.
  - When cnt == NIBBLES-1 at the edge, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - `sum` is the result register and `cout` is the carry reg; both are held stable.
  - On out_ready, go to IDLE.
- in_ready and out_valid are decoded from state only. They have no combinational path from in_valid or out_ready.
- Operands are sampled only at the accept edge; changes on a, b or cin afterwards have no effect.
- Reset in any state, including mid-RUN:
  - Next state is IDLE; the operation is discarded.
  - Result register, carry reg, shift registers and cnt are cleared to 0.
- WIDTH == 4 degenerates to a single RUN cycle.

## Timing

- Reset values: in_ready=1 (IDLE), out_valid=0, sum=0, cout=0.
- Accept at edge E0 puts the FSM in RUN. Nibble i is computed in the cycle after edge E0+i and registered at edge E0+i+1.
- out_valid rises after edge E0+NIBBLES, which is 4 cycles for WIDTH=16.
- With out_ready held high:
  - Result handshake occurs at edge E0+NIBBLES+1.
  - in_ready is high again after that edge.
  - Next accept is no earlier than E0+NIBBLES+2.
  - Sustained throughput is one operation per NIBBLES+2 cycles.
- out_ready low holds the FSM in DONE indefinitely with sum and cout unchanged.
- Critical path is one 4-bit `adder` plus register setup; carry never ripples combinationally across nibbles.

## Test plan

- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1:
  - sum=0x5555, cout=0.
  - out_valid high exactly 4 cycles after accept, for exactly 1 cycle.
- a=0xFFFF, b=0x0000, cin=1: sum=0x0000, cout=1 (carry propagates through every nibble). Also a=0xFFFF, b=0xFFFF, cin=1: sum=0xFFFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven.
  - sum and cout stay stable and in_ready stays 0.
  - After out_ready=1, the FSM returns to IDLE and the pending operands are accepted next cycle.
- Assert rst for one cycle after 2 RUN cycles of 0xABCD+0x1111:
  - Next cycle shows out_valid=0, sum=0, cout=0, in_ready=1.
  - A following 0x0001+0x0001, cin=0 yields 0x0002, cout=0.
- 1000 random operations (random cin, random in_valid and out_ready gaps) compared against a golden {cout,sum} = a+b+cin. Also check the one-per-6-cycle throughput when in_valid and out_ready are tied high.
- Repeat the random test at WIDTH=4 and WIDTH=32: latency is 1 and 8 cycles respectively and all results match golden.
